mfp_timer_bank: RTL
===================

Name: mfp_timer_bank

Overview:
Parametrised bank of NUM_CH MFP68901-style timers with a shared register interface. It is the successor to the single 8-bit MFP timer. Each channel adds a configurable counter width, one-shot mode, cascading from the previous channel's timeout, and selectable T_I polarity. The bank sits inside the MFP next to the interrupt controller, which consumes T_O_PULSE. The whole block runs in the timer clock domain.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
WIDTH, 8, data/counter width per channel (8..16)
TI_POL, 4'b1111, per-channel T_I active level (1 = high/rising, 0 = low/falling)

Ports:
XCLK_I  in  1  timer clock; all logic on its rising edge
RST  in  1  reset, synchronous, active-high
SEL  in  $clog2(NUM_CH)  channel selected for register access
DAT_WE  in  1  write data register of SEL channel
DAT_I  in  WIDTH  data register write value
DAT_O  out  WIDTH  counter value of SEL channel, registered
CTRL_WE  in  1  write control register of SEL channel
CTRL_I  in  7  [2:0] prescale, [3] mode, [4] T_O clear strobe, [5] cascade, [6] one-shot
CTRL_O  out  6  {ctrl[6:5], ctrl[3:0]} of SEL channel, combinational
T_I  in  NUM_CH  external trigger inputs, asynchronous
T_O  out  NUM_CH  timer outputs, toggle on each timeout
T_O_PULSE  out  NUM_CH  one-cycle timeout strobes
PULSE_MODE  out  NUM_CH  channel is in pulse-width mode
EVENT_MODE  out  NUM_CH  channel is in event-count mode

Behaviour:
- Reset: all control, data, counters, prescalers and synchronisers cleared. T_O=0, T_O_PULSE=0, DAT_O=0.
- Mode decode uses ctrl[3:0]:
  - 0000 = stopped.
  - 0xxx (xxx≠0) = delay mode.
  - 1000 = event mode.
  - 1xxx (xxx≠0) = pulse mode.
  - started = (ctrl[3:0]≠0).
- Prescaler: prescale codes 1..7 divide by 4, 10, 16, 50, 64, 100, 200.
  - The 8-bit prescaler counter counts to divisor-1, then wraps and asserts a one-cycle tick.
  - The prescaler counter is held at 0 when ctrl[2:0]=0.
- T_I path: 2-flop synchroniser, then polarity XOR with TI_POL[i], then edge register. The active edge is detected 3 cycles after the pin change.
- Count enable (cnt) per channel:
  - delay: prescaler tick.
  - event: active edge of synced T_I.
  - pulse: prescaler tick AND synced T_I at active level.
  - cascade (ctrl[5]=1, i>0, channel started): T_O_PULSE[i-1] replaces the prescaler tick in delay and pulse modes.
  - ctrl[5] is ignored on channel 0.
- Counter behaviour on cnt:
  - If counter==1, the counter reloads from data, T_O toggles, and T_O_PULSE=1 in the next cycle (latency 1).
  - Otherwise the counter decrements.
  - Counter 0 decrements to 2^WIDTH-1, so data=0 gives a period of 2^WIDTH.
- One-shot (ctrl[6]=1): on timeout, ctrl[3:0] clears to 0 in the same edge as the reload. The channel stops and the counter holds the data value.
- DAT_WE:
  - Always updates data.
  - Loads the counter only if the channel is stopped.
  - If DAT_WE and a timeout occur in the same cycle, the reload uses DAT_I.
- CTRL_WE:
  - Updates ctrl[6:5] and ctrl[3:0].
  - ctrl[4]=1 clears T_O, and this takes priority over a simultaneous toggle.
  - A cnt occurring in the same cycle is evaluated under the old control.
  - Stopping a channel freezes its counter value.
- Read: DAT_O <= counter[SEL] every cycle, giving 1-cycle read latency.
- Reset mid-operation aborts any pending pulse; no T_O_PULSE is emitted in the reset cycle or the following cycle.
- PULSE_MODE and EVENT_MODE are combinational decodes of ctrl.

Decomposition:
- Package mfp_timer_pkg:
  - mode encodings (STOP, DELAY, EVENT, PULSE);
  - control bit indices;
  - prescaler divisor table function presc_max(code) returning 3, 9, 15, 49, 63, 99, 199;
  - control struct typedef.
- Sub-module mfp_timer_chan (one channel: synchroniser, prescaler, counter, mode logic) with cascade input casc_i. The bank generates NUM_CH instances and handles SEL muxing plus DAT_O registration.

Test Plan:
- Delay mode: ch0 data=3, ctrl=0x01 (div 4) -> T_O_PULSE[0] every 12 cycles; T_O[0] toggles each pulse; DAT_O sequence 3,2,1,3.
- Event mode: ch1 data=2, ctrl=0x08, TI_POL[1]=1; 4 rising edges on T_I[1] -> 2 pulses; each pulse arrives 4 cycles after the qualifying edge; counter returns to 2.
- Pulse mode: ch2 data=5, ctrl=0x09 (div 4), T_I[2] high for 12 cycles then low -> counter 5→2 then frozen; no pulse emitted.
- Cascade: ch0 data=2, ctrl=0x01; ch1 data=3, ctrl=0x21 -> ch1 pulses once per 3 ch0 pulses (every 24 cycles).
- One-shot: ch3 data=4, ctrl=0x41 -> exactly one T_O_PULSE after 16 cycles; CTRL_O afterwards reads 0x20 with ctrl[3:0]=0; counter=4.
- Boundaries:
  - WIDTH=16, data=0, delay div 4 -> period 262144 cycles.
  - DAT_WE 7 in the timeout cycle -> reload 7.
  - CTRL_WE with ctrl[4]=1 in the toggle cycle -> T_O=0.
  - RST asserted mid-count -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mfp_timer_pkg.sv
// Shared types and helpers for the MFP timer bank: mode encodings,
// control register layout and the prescaler divisor table.
package mfp_timer_pkg;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_DELAY = 2'd1,
    MODE_EVENT = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  // Bit positions within the 7-bit control write bus.
  localparam int unsigned CTRL_PRESC_LSB   = 0;
  localparam int unsigned CTRL_MODE_BIT    = 3;
  localparam int unsigned CTRL_CLR_BIT     = 4;
  localparam int unsigned CTRL_CASC_BIT    = 5;
  localparam int unsigned CTRL_ONESHOT_BIT = 6;

  // Stored control; the T_O clear strobe is not stored. Packed layout
  // matches the CTRL_O readback {ctrl[6:5], ctrl[3:0]}.
  typedef struct packed {
    logic       oneshot;
    logic       casc;
    logic       mode;
    logic [2:0] presc;
  } ctrl_t;

  // Terminal count of the prescaler counter (divisor - 1).
  function automatic logic [7:0] presc_max(input logic [2:0] code);
    logic [7:0] m;
    case (code)
      3'd1:    m = 8'd3;
      3'd2:    m = 8'd9;
      3'd3:    m = 8'd15;
      3'd4:    m = 8'd49;
      3'd5:    m = 8'd63;
      3'd6:    m = 8'd99;
      3'd7:    m = 8'd199;
      default: m = 8'd0;
    endcase
    return m;
  endfunction

  function automatic mode_e mode_decode(input ctrl_t c);
    mode_e m;
    if (c.presc == 3'd0) m = c.mode ? MODE_EVENT : MODE_STOP;
    else                 m = c.mode ? MODE_PULSE : MODE_DELAY;
    return m;
  endfunction

  function automatic ctrl_t ctrl_unpack(input logic [6:0] bus);
    ctrl_t c;
    c.oneshot = bus[CTRL_ONESHOT_BIT];
    c.casc    = bus[CTRL_CASC_BIT];
    c.mode    = bus[CTRL_MODE_BIT];
    c.presc   = bus[CTRL_PRESC_LSB +: 3];
    return c;
  endfunction

endpackage

// File: rtl/mfp_timer_chan.sv
// One timer channel: T_I synchroniser and edge detect, prescaler,
// down-counter with reload, mode decode and one-shot/cascade handling.
module mfp_timer_chan
  import mfp_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        TI_POL   = 1'b1,
  parameter logic        HAS_CASC = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ti,
  input  logic             casc_i,
  input  logic             dat_we,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             ctrl_we,
  input  logic [6:0]       ctrl_i,
  output logic [WIDTH-1:0] count,
  output logic [5:0]       ctrl_o,
  output logic             t_o,
  output logic             t_o_pulse,
  output logic             pulse_mode,
  output logic             event_mode
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ctrl_t            ctrl;
  mode_e            mode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_nxt;
  logic [7:0]       presc_cnt;
  logic             presc_tick;
  logic             tick;
  logic             s1, s2, lvl, lvl_q;
  logic             ti_edge;
  logic             cnt;
  logic             timeout;

  // Count-enable selection from mode, prescaler, cascade and T_I.
  always_comb begin
    mode       = mode_decode(ctrl);
    presc_tick = (ctrl.presc != 3'd0) && (presc_cnt >= presc_max(ctrl.presc));
    tick       = (HAS_CASC && ctrl.casc && (mode != MODE_STOP)) ? casc_i : presc_tick;
    ti_edge    = lvl & ~lvl_q;
    case (mode)
      MODE_DELAY: cnt = tick;
      MODE_EVENT: cnt = ti_edge;
      MODE_PULSE: cnt = tick & lvl;
      default:    cnt = 1'b0;
    endcase
    timeout  = cnt && (count == ONE);
    data_nxt = dat_we ? dat_i : data;
  end

  // Two-flop synchroniser, polarity-normalised level, and edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      s1    <= ti;
      s2    <= s1;
      lvl   <= s2 ^ ~TI_POL;
      lvl_q <= lvl;
    end
  end

  // Prescaler: wraps at divisor-1, held at zero when no prescale is set.
  always_ff @(posedge clk) begin
    if (rst || ctrl.presc == 3'd0) presc_cnt <= '0;
    else if (presc_tick)           presc_cnt <= '0;
    else                           presc_cnt <= presc_cnt + 8'd1;
  end

  // Data register and down-counter; a same-cycle write feeds the reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else begin
      data <= data_nxt;
      if (cnt)                                count <= (count == ONE) ? data_nxt : count - ONE;
      else if (dat_we && mode == MODE_STOP)   count <= dat_i;
    end
  end

  // Timer output toggle and timeout strobe; the clear strobe beats a toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_o       <= 1'b0;
      t_o_pulse <= 1'b0;
    end else begin
      t_o_pulse <= timeout;
      if (ctrl_we && ctrl_i[CTRL_CLR_BIT]) t_o <= 1'b0;
      else if (timeout)                    t_o <= ~t_o;
    end
  end

  // Control register; a host write wins over the one-shot self-stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (ctrl_we) begin
      ctrl <= ctrl_unpack(ctrl_i);
    end else if (timeout && ctrl.oneshot) begin
      ctrl.mode  <= 1'b0;
      ctrl.presc <= 3'd0;
    end
  end

  assign ctrl_o     = ctrl;
  assign pulse_mode = (mode == MODE_PULSE);
  assign event_mode = (mode == MODE_EVENT);

endmodule

// File: rtl/mfp_timer_bank.sv
// Bank of MFP-style timer channels behind a shared register port.
// Channel i>0 may cascade from the timeout strobe of channel i-1.
module mfp_timer_bank
  import mfp_timer_pkg::*;
#(
  parameter int unsigned       NUM_CH = 4,
  parameter int unsigned       WIDTH  = 8,
  parameter logic [NUM_CH-1:0] TI_POL = {NUM_CH{1'b1}}
) (
  input  logic                                          XCLK_I,
  input  logic                                          RST,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] SEL,
  input  logic                                          DAT_WE,
  input  logic [WIDTH-1:0]                              DAT_I,
  output logic [WIDTH-1:0]                              DAT_O,
  input  logic                                          CTRL_WE,
  input  logic [6:0]                                    CTRL_I,
  output logic [5:0]                                    CTRL_O,
  input  logic [NUM_CH-1:0]                             T_I,
  output logic [NUM_CH-1:0]                             T_O,
  output logic [NUM_CH-1:0]                             T_O_PULSE,
  output logic [NUM_CH-1:0]                             PULSE_MODE,
  output logic [NUM_CH-1:0]                             EVENT_MODE
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0]  count  [NUM_CH];
  logic [5:0]        ctrl_r [NUM_CH];
  logic [NUM_CH-1:0] casc;

  // Cascade source for each channel is its lower neighbour's timeout.
  always_comb begin
    casc = '0;
    for (int unsigned i = 1; i < NUM_CH; i++) casc[i] = T_O_PULSE[i-1];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mfp_timer_chan #(
      .WIDTH    (WIDTH),
      .TI_POL   (TI_POL[i]),
      .HAS_CASC (i > 0)
    ) u_chan (
      .clk        (XCLK_I),
      .rst        (RST),
      .ti         (T_I[i]),
      .casc_i     (casc[i]),
      .dat_we     (DAT_WE && (SEL == SEL_W'(i))),
      .dat_i      (DAT_I),
      .ctrl_we    (CTRL_WE && (SEL == SEL_W'(i))),
      .ctrl_i     (CTRL_I),
      .count      (count[i]),
      .ctrl_o     (ctrl_r[i]),
      .t_o        (T_O[i]),
      .t_o_pulse  (T_O_PULSE[i]),
      .pulse_mode (PULSE_MODE[i]),
      .event_mode (EVENT_MODE[i])
    );
  end

  // Registered counter readback of the selected channel.
  always_ff @(posedge XCLK_I) begin
    if (RST) DAT_O <= '0;
    else     DAT_O <= count[SEL];
  end

  // Combinational control readback of the selected channel.
  always_comb CTRL_O = ctrl_r[SEL];

endmodule
